// File: rtl/intersection_pkg.sv
// Shared types and defaults for the two-head intersection controller.
package intersection_pkg;

  localparam int TIMER_W = 8;

  localparam int DEF_MAIN_MIN_GREEN = 10;
  localparam int DEF_SIDE_MIN_GREEN = 4;
  localparam int DEF_SIDE_MAX_GREEN = 12;
  localparam int DEF_YELLOW_T       = 3;
  localparam int DEF_ALL_RED_T      = 2;
  localparam int DEF_WALK_T         = 6;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Saturating cycles-in-state counter, cleared synchronously on a state change.
module phase_timer
  import intersection_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count != {W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Moore FSM sequencing main/side heads and pedestrian walk, main resting on green.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int MAIN_MIN_GREEN = DEF_MAIN_MIN_GREEN,
  parameter int SIDE_MIN_GREEN = DEF_SIDE_MIN_GREEN,
  parameter int SIDE_MAX_GREEN = DEF_SIDE_MAX_GREEN,
  parameter int YELLOW_T       = DEF_YELLOW_T,
  parameter int ALL_RED_T      = DEF_ALL_RED_T,
  parameter int WALK_T         = DEF_WALK_T
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_car,
  input  logic       ped_req,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic [2:0] phase
);

  if (MAIN_MIN_GREEN < 1 || MAIN_MIN_GREEN > 255 ||
      SIDE_MIN_GREEN < 1 || SIDE_MIN_GREEN > 255 ||
      SIDE_MAX_GREEN < 1 || SIDE_MAX_GREEN > 255 ||
      YELLOW_T < 1 || YELLOW_T > 255 ||
      ALL_RED_T < 1 || ALL_RED_T > 255 ||
      WALK_T < 1 || WALK_T > 255 ||
      SIDE_MIN_GREEN > SIDE_MAX_GREEN ||
      WALK_T > SIDE_MAX_GREEN) begin : g_bad_params
    $error("intersection_controller: illegal timing parameters");
  end

  localparam logic [TIMER_W-1:0] MAIN_MIN_M1  = TIMER_W'(MAIN_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] SIDE_MIN_M1  = TIMER_W'(SIDE_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] SIDE_PED_M1  = TIMER_W'(max_int(SIDE_MIN_GREEN, WALK_T) - 1);
  localparam logic [TIMER_W-1:0] SIDE_MAX_M1  = TIMER_W'(SIDE_MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YELLOW_M1    = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] ALL_RED_M1   = TIMER_W'(ALL_RED_T - 1);
  localparam logic [TIMER_W-1:0] WALK_LIMIT   = TIMER_W'(WALK_T);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer;
  logic                 state_change;
  logic                 ped_pending, ped_served;
  logic [TIMER_W-1:0]   side_min_m1;

  assign state_change = (state_d != state_q);
  assign side_min_m1  = ped_served ? SIDE_PED_M1 : SIDE_MIN_M1;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_change),
    .count (timer)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MAIN_GREEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if (timer >= MAIN_MIN_M1 && (side_car || ped_pending)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (timer == YELLOW_M1)  state_d = ALL_RED_A;
      ALL_RED_A:   if (timer == ALL_RED_M1) state_d = SIDE_GREEN;
      SIDE_GREEN:  if (timer == SIDE_MAX_M1 || (timer >= side_min_m1 && !side_car))
                     state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (timer == YELLOW_M1)  state_d = ALL_RED_B;
      ALL_RED_B:   if (timer == ALL_RED_M1) state_d = MAIN_GREEN;
      default:     state_d = MAIN_GREEN;
    endcase
  end

  // A request arriving on the cycle that opens the side phase is served in that phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
      ped_served  <= 1'b0;
    end else if (state_q == ALL_RED_A && state_d == SIDE_GREEN) begin
      ped_served  <= ped_pending | ped_req;
      ped_pending <= 1'b0;
    end else begin
      ped_pending <= ped_pending | ped_req;
      if (state_q == SIDE_GREEN && state_d != SIDE_GREEN) begin
        ped_served <= 1'b0;
      end
    end
  end

  always_comb begin
    main_red    = 1'b1;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b1;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    walk        = 1'b0;
    case (state_q)
      MAIN_GREEN:  begin main_red = 1'b0; main_green  = 1'b1; end
      MAIN_YELLOW: begin main_red = 1'b0; main_yellow = 1'b1; end
      SIDE_GREEN: begin
        side_red   = 1'b0;
        side_green = 1'b1;
        walk       = ped_served && (timer < WALK_LIMIT);
      end
      SIDE_YELLOW: begin side_red = 1'b0; side_yellow = 1'b1; end
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule
